// File: rtl/aib_adapt_pkg.sv
// Shared constants and types for the AIB TX adapt feeder.
package aib_adapt_pkg;

  localparam logic [1:0] FMODE_1TO1 = 2'b00;
  localparam logic [1:0] FMODE_2TO1 = 2'b01;
  localparam logic [1:0] FMODE_4TO1 = 2'b10;
  localparam logic [1:0] FMODE_REG  = 2'b11;

  localparam int BEAT_W    = 80;
  localparam int NUM_BEATS = 4;
  localparam int WORD_W    = BEAT_W * NUM_BEATS;

  typedef enum logic {ALIGN, RUN} state_t;

  // Index of the highest beat carrying data for a given FIFO ratio.
  function automatic int last_beat(input logic [1:0] mode);
    case (mode)
      FMODE_1TO1: return 0;
      FMODE_2TO1: return 1;
      default:    return NUM_BEATS - 1;
    endcase
  endfunction

endpackage

// File: rtl/aib_adapt_mkapply.sv
// Combinational per-beat masking and word-marker insertion.
module aib_adapt_mkapply
  import aib_adapt_pkg::*;
(
  input  logic [1:0]        mode,
  input  logic              wm_en,
  input  logic [4:0]        mkbit,
  input  logic [WORD_W-1:0] word_in,
  output logic [WORD_W-1:0] word_out
);

  logic [6:0] mk_pos;
  logic       mk_on;
  int         last;

  assign mk_pos = 7'd79 - {2'b00, mkbit};
  assign mk_on  = wm_en && (mode != FMODE_REG);
  assign last   = last_beat(mode);

  // Only the final active beat carries a 1 marker; earlier active beats carry 0.
  always_comb begin
    word_out = '0;
    for (int b = 0; b < NUM_BEATS; b++) begin
      if (b <= last) begin
        word_out[b*BEAT_W +: BEAT_W] = word_in[b*BEAT_W +: BEAT_W];
        if (mk_on)
          word_out[b*BEAT_W + int'(mk_pos)] = (b == last);
      end
    end
  end

endmodule

// File: rtl/aib_adapt_txmkins.sv
// TX adapt feeder: post-reset idle alignment run, valid/ready intake,
// marker insertion and saturating underrun count.
module aib_adapt_txmkins
  import aib_adapt_pkg::*;
#(
  parameter int ALIGN_WORDS = 16,
  parameter int UFLW_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [WORD_W-1:0]     i_data,
  input  logic [1:0]            r_fifo_mode,
  input  logic                  r_wm_en,
  input  logic [4:0]            r_mkbit,
  output logic [WORD_W-1:0]     o_data,
  output logic                  o_word_vld,
  output logic                  o_align_done,
  output logic [UFLW_CNT_W-1:0] o_uflw_cnt
);

  localparam int CNT_W = (ALIGN_WORDS > 1) ? $clog2(ALIGN_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALIGN_WORDS - 1);

  state_t            state;
  logic [CNT_W-1:0]  align_cnt;
  logic              bypass;
  logic              xfer;
  logic [WORD_W-1:0] mk_in;
  logic [WORD_W-1:0] mk_out;

  assign bypass = (r_fifo_mode == FMODE_REG);
  // Bypass is ready from the first cycle after release, before the FSM edge.
  assign o_ready = !rst && ((state == RUN) || bypass);
  assign xfer    = i_valid && o_ready;
  assign mk_in   = xfer ? i_data : '0;

  aib_adapt_mkapply u_mkapply (
    .mode     (r_fifo_mode),
    .wm_en    (r_wm_en),
    .mkbit    (r_mkbit),
    .word_in  (mk_in),
    .word_out (mk_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ALIGN;
      align_cnt    <= '0;
      o_data       <= '0;
      o_word_vld   <= 1'b0;
      o_align_done <= 1'b0;
      o_uflw_cnt   <= '0;
    end else if (bypass) begin
      state        <= RUN;
      o_align_done <= 1'b1;
      o_word_vld   <= i_valid;
      if (i_valid)
        o_data <= i_data;
    end else if (state == ALIGN) begin
      o_data     <= mk_out;
      o_word_vld <= 1'b0;
      if (align_cnt == CNT_LAST) begin
        state        <= RUN;
        o_align_done <= 1'b1;
      end else begin
        align_cnt <= align_cnt + 1'b1;
      end
    end else begin
      o_data     <= mk_out;
      o_word_vld <= i_valid;
      if (!i_valid && (o_uflw_cnt != '1))
        o_uflw_cnt <= o_uflw_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_aib_adapt_txmkins.sv
// Directed self-checking bench for aib_adapt_txmkins (ALIGN_WORDS=16, 16-bit counter).
module tb_aib_adapt_txmkins;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic [319:0] i_data;
  logic [1:0]   r_fifo_mode;
  logic         r_wm_en;
  logic [4:0]   r_mkbit;
  logic [319:0] o_data;
  logic         o_word_vld;
  logic         o_align_done;
  logic [15:0]  o_uflw_cnt;

  int n_cmp = 0;
  int n_err = 0;

  aib_adapt_txmkins #(.ALIGN_WORDS(16), .UFLW_CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data       (i_data),
    .r_fifo_mode  (r_fifo_mode),
    .r_wm_en      (r_wm_en),
    .r_mkbit      (r_mkbit),
    .o_data       (o_data),
    .o_word_vld   (o_word_vld),
    .o_align_done (o_align_done),
    .o_uflw_cnt   (o_uflw_cnt)
  );

  always #5 clk = ~clk;

  // Counts negedges after release until o_ready rises; bounded.
  task automatic wait_ready(output int edges);
    edges = 0;
    while (!o_ready && edges < 40) begin
      @(negedge clk);
      #1;
      edges++;
    end
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL wait_ready: o_ready=%b after %0d cycles, want 1", o_ready, edges);
    end
  endtask

  task automatic do_reset(input logic [1:0] mode, input logic wm, input logic [4:0] mk,
                          output int edges);
    @(negedge clk);
    rst = 1'b1;
    i_valid = 1'b0;
    i_data = '0;
    r_fifo_mode = mode;
    r_wm_en = wm;
    r_mkbit = mk;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    wait_ready(edges);
  endtask

  task automatic test_reset();
    logic [319:0] exp;
    rst = 1'b1; i_valid = 1'b0; i_data = '0;
    r_fifo_mode = 2'b10; r_wm_en = 1'b1; r_mkbit = 5'd0;
    repeat (3) @(negedge clk);
    n_cmp++; if (o_data !== '0) begin n_err++; $display("FAIL rst_data: got %h want 0", o_data); end
    n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", o_ready); end
    n_cmp++; if (o_word_vld !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %b want 0", o_word_vld); end
    n_cmp++; if (o_align_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", o_align_done); end
    n_cmp++; if (o_uflw_cnt !== 16'd0) begin n_err++; $display("FAIL rst_uflw: got %h want 0", o_uflw_cnt); end
    rst = 1'b0;
    #1;
    exp = '0;
    exp[319] = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      n_cmp++;
      if (o_ready !== (i == 16)) begin
        n_err++; $display("FAIL align_ready cyc %0d: got %b want %b", i, o_ready, (i == 16));
      end
      n_cmp++;
      if (o_align_done !== (i == 16)) begin
        n_err++; $display("FAIL align_done cyc %0d: got %b want %b", i, o_align_done, (i == 16));
      end
      if (i > 0) begin
        n_cmp++;
        if (o_data !== exp || o_word_vld !== 1'b0) begin
          n_err++; $display("FAIL align_idle cyc %0d: got %h vld %b want %h vld 0", i, o_data, o_word_vld, exp);
        end
      end
    end
  endtask

  task automatic test_mode4_data();
    logic [319:0] exp;
    i_valid = 1'b1; i_data = '1;
    @(negedge clk); #1;
    i_valid = 1'b0; i_data = '0;
    exp = '1; exp[79] = 1'b0; exp[159] = 1'b0; exp[239] = 1'b0;
    n_cmp++; if (o_data !== exp) begin n_err++; $display("FAIL m4_ones: got %h want %h", o_data, exp); end
    n_cmp++; if (o_word_vld !== 1'b1) begin n_err++; $display("FAIL m4_vld: got %b want 1", o_word_vld); end
    @(negedge clk); #1;
    exp = '0; exp[319] = 1'b1;
    n_cmp++; if (o_data !== exp) begin n_err++; $display("FAIL m4_idle: got %h want %h", o_data, exp); end
    n_cmp++; if (o_uflw_cnt !== 16'd1) begin n_err++; $display("FAIL m4_uflw: got %0d want 1", o_uflw_cnt); end
  endtask

  task automatic test_mode2_and_1();
    logic [319:0] exp;
    int n;
    do_reset(2'b01, 1'b1, 5'd3, n);
    n_cmp++; if (n !== 16) begin n_err++; $display("FAIL m2_align_len: got %0d want 16", n); end
    i_valid = 1'b1; i_data = '0;
    @(negedge clk); #1;
    i_data = '1;
    exp = '0; exp[156] = 1'b1;
    n_cmp++; if (o_data !== exp) begin n_err++; $display("FAIL m2_zero: got %h want %h", o_data, exp); end
    @(negedge clk); #1;
    i_valid = 1'b0; i_data = '0;
    exp = '0; exp[159:0] = '1; exp[76] = 1'b0;
    n_cmp++; if (o_data !== exp) begin n_err++; $display("FAIL m2_ones: got %h want %h", o_data, exp); end

    do_reset(2'b00, 1'b1, 5'd31, n);
    i_valid = 1'b1; i_data = '0;
    @(negedge clk); #1;
    i_valid = 1'b0;
    exp = '0; exp[48] = 1'b1;
    n_cmp++; if (o_data !== exp) begin n_err++; $display("FAIL m1_mk31: got %h want %h", o_data, exp); end

    do_reset(2'b00, 1'b0, 5'd0, n);
    i_valid = 1'b1; i_data = '1;
    @(negedge clk); #1;
    i_valid = 1'b0; i_data = '0;
    exp = '0; exp[79:0] = '1;
    n_cmp++; if (o_data !== exp) begin n_err++; $display("FAIL m1_nowm: got %h want %h", o_data, exp); end

    do_reset(2'b10, 1'b0, 5'd0, n);
    i_valid = 1'b1; i_data = '1;
    @(negedge clk); #1;
    i_valid = 1'b0; i_data = '0;
    exp = '1;
    n_cmp++; if (o_data !== exp) begin n_err++; $display("FAIL m4_nowm: got %h want %h", o_data, exp); end
  endtask

  task automatic test_underrun();
    logic [319:0] exp;
    int n;
    do_reset(2'b10, 1'b1, 5'd0, n);
    n_cmp++; if (o_uflw_cnt !== 16'd0) begin n_err++; $display("FAIL uf_start: got %0d want 0", o_uflw_cnt); end
    exp = '0; exp[319] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (o_data !== exp || o_word_vld !== 1'b0) begin
        n_err++; $display("FAIL uf_idle %0d: got %h vld %b want %h vld 0", i, o_data, o_word_vld, exp);
      end
    end
    n_cmp++; if (o_uflw_cnt !== 16'd5) begin n_err++; $display("FAIL uf_five: got %0d want 5", o_uflw_cnt); end
    i_valid = 1'b1; i_data = '0;
    @(negedge clk); #1;
    i_valid = 1'b0;
    n_cmp++;
    if (o_uflw_cnt !== 16'd5 || o_word_vld !== 1'b1) begin
      n_err++; $display("FAIL uf_hold: got cnt %0d vld %b want 5 vld 1", o_uflw_cnt, o_word_vld);
    end
    repeat (65539) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++; if (o_uflw_cnt !== 16'hFFFF) begin n_err++; $display("FAIL uf_sat: got %h want ffff", o_uflw_cnt); end
  endtask

  task automatic test_bypass();
    logic [319:0] pat;
    logic [319:0] pat2;
    int n;
    pat = {80'hF234_5678_9ABC_DEF0_5678, 80'h1234_5678_9ABC_DEF0_5678,
           80'h8765_4321_0FED_CBA9_1234, 80'h1234_5678_9ABC_DEF0_5678};
    pat2 = ~pat;
    do_reset(2'b11, 1'b1, 5'd0, n);
    n_cmp++; if (n !== 0) begin n_err++; $display("FAIL byp_ready_lat: got %0d want 0", n); end
    i_valid = 1'b1; i_data = pat;
    @(negedge clk); #1;
    i_data = pat2;
    n_cmp++; if (o_data !== pat) begin n_err++; $display("FAIL byp_pat: got %h want %h", o_data, pat); end
    n_cmp++; if (o_word_vld !== 1'b1) begin n_err++; $display("FAIL byp_vld: got %b want 1", o_word_vld); end
    @(negedge clk); #1;
    i_valid = 1'b0; i_data = '0;
    n_cmp++; if (o_data !== pat2) begin n_err++; $display("FAIL byp_b2b: got %h want %h", o_data, pat2); end
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (o_data !== pat2) begin n_err++; $display("FAIL byp_hold: got %h want %h", o_data, pat2); end
    n_cmp++; if (o_uflw_cnt !== 16'd0) begin n_err++; $display("FAIL byp_uflw: got %0d want 0", o_uflw_cnt); end
    n_cmp++; if (o_align_done !== 1'b1) begin n_err++; $display("FAIL byp_done: got %b want 1", o_align_done); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    do_reset(2'b10, 1'b1, 5'd0, n);
    repeat (2) @(negedge clk);
    i_valid = 1'b1; i_data = {4{80'hAAAA_5555_AAAA_5555_AAAA}};
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (o_data !== '0 || o_ready !== 1'b0 || o_word_vld !== 1'b0 ||
        o_align_done !== 1'b0 || o_uflw_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL midrst: data %h ready %b vld %b done %b uflw %0d want all 0",
               o_data, o_ready, o_word_vld, o_align_done, o_uflw_cnt);
    end
    i_valid = 1'b0; i_data = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    wait_ready(n);
    n_cmp++; if (n !== 16) begin n_err++; $display("FAIL midrst_align_len: got %0d want 16", n); end
  endtask

  initial begin
    test_reset();
    test_mode4_data();
    test_mode2_and_1();
    test_underrun();
    test_bypass();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aib_adapt_txmkins.md
Name: aib_adapt_txmkins

Overview:
- Upstream neighbour of the TX adapt channel; drives its 320-bit FIFO-mode input (data_in_f) once per write-clock cycle.
- Accepts user words through a valid/ready handshake and zeroes the beats the configured FIFO ratio does not use.
- Inserts word-marker bits into each 80-bit beat.
- After reset, emits a programmable run of idle words so the TX phase-compensation FIFO settles before live data arrives.
- Substitutes idle words on underrun and counts each substitution.

Parameters:
- ALIGN_WORDS, 16: idle words emitted after reset before accepting data; must be ≥1.
- UFLW_CNT_W, 16: width of the saturating underrun counter.

Ports:
- clk  in  1  write clock (same net as the TX FIFO write clock).
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  user word valid.
- o_ready  out  1  block accepts i_data this cycle.
- i_data  in  320  user word; beat n = bits [80n+79:80n].
- r_fifo_mode  in  2  00 = 1:1, 01 = 2:1, 10 = 4:1, 11 = register/bypass.
- r_wm_en  in  1  word-marker insertion enable.
- r_mkbit  in  5  marker bit index within a beat = 79 - r_mkbit.
- o_data  out  320  to TX channel data_in_f.
- o_word_vld  out  1  o_data carries a user word (not idle).
- o_align_done  out  1  alignment phase complete.
- o_uflw_cnt  out  UFLW_CNT_W  saturating count of idle words inserted in RUN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: o_data = 0, o_word_vld = 0, o_ready = 0, o_align_done = 0, o_uflw_cnt = 0, state = ALIGN, align counter = 0.
- Configuration: r_* inputs are quasi-static. Changing them is legal only while rst is high. Mid-run changes have undefined data but must not hang the FSM.
- FSM, two states:
  - ALIGN: o_ready = 0; each cycle outputs an idle word and increments the align counter. When the counter reaches ALIGN_WORDS-1, go to RUN on the next edge.
  - RUN: o_ready = 1; o_align_done = 1, registered, asserted the first cycle in RUN. RUN is left only by reset.
- Bypass mode (r_fifo_mode = 11): the FSM starts directly in RUN after reset deassertion. No markers, no beat masking. o_data = i_data when i_valid, else o_data holds its last value.
- Handshake: transfer occurs when i_valid & o_ready. Latency is 1 cycle: the word transferred at edge k appears on o_data after edge k, with o_word_vld = 1.
- Underrun: i_valid = 0 in RUN (non-bypass) produces an idle word, o_word_vld = 0, and o_uflw_cnt increments. The counter saturates at all-ones and clears only on rst. Bypass mode never counts.
- Idle word: all payload bits 0, markers applied as below.
- Active beats: mode 00 uses beat 0; mode 01 uses beats 0-1; mode 10 uses beats 0-3. Inactive beats are forced to 0, including markers.
- Markers (r_wm_en = 1, non-bypass), at bit M = 79 - r_mkbit in each active beat:
  - The last active beat (beat 1 in 2:1, beat 3 in 4:1) has bit M = 1.
  - All other active beats have bit M = 0.
  - In mode 00 the single beat has bit M = 1.
  - Marker bits override user data at bit M.
- r_wm_en = 0: user data passes unmodified within active beats.
- Simultaneous events: rst overrides everything. Asserting rst mid-RUN returns the block to ALIGN and clears the counters, asynchronously on assertion. Deassertion is expected to be synchronous to clk.

Decomposition:
- Shared package aib_adapt_pkg holds:
  - FIFO-mode constants FMODE_1TO1 = 2'b00, FMODE_2TO1 = 2'b01, FMODE_4TO1 = 2'b10, FMODE_REG = 2'b11.
  - Beat width 80 and beats-per-word 4.
  - The state enum {ALIGN, RUN}.
- One sub-module: aib_adapt_mkapply. It is combinational and does the per-beat masking and marker insertion from mode, wm_en, mkbit and the raw word. Instantiate it once; the top holds the FSM, counters and output register.

Test Plan:
- Reset with ALIGN_WORDS = 16, mode 10, wm_en = 1, mkbit = 0 -> o_ready = 0 for exactly 16 cycles. o_data = bit 319 set, all else 0 (0x8000… in the top beat). o_align_done rises in cycle 17.
- RUN, mode 10, send i_data = all-ones -> next cycle o_data bits 79, 159, 239 = 0, bit 319 = 1, all other bits 1; o_word_vld = 1.
- Mode 01, mkbit = 3, i_data = 0 -> o_data bit 156 = 1, bit 76 = 0, bits [319:160] = 0.
- Drop i_valid for 5 cycles in RUN -> five idle words with o_word_vld = 0, o_uflw_cnt = 5. Then force 2^UFLW_CNT_W + 3 underruns -> o_uflw_cnt saturates at 0xFFFF.
- Mode 11, i_data = 0x1234…5678 pattern -> appears on o_data unaltered 1 cycle later, o_ready = 1 from the first post-reset cycle, no marker bits, o_uflw_cnt stays 0.
- Assert rst mid-RUN with traffic -> outputs immediately return to 0, o_ready = 0. After release, the full 16-word ALIGN phase repeats.
